btb_upd_sched: RTL and testbench
================================

Name: btb_upd_sched

Overview:
- Schedules all writes into the branch target buffer's single training port.
- Accepts up to SIMBRCOM branch-commit updates per cycle from the commit stage and queues them in a small FIFO. Drains one per cycle into the BTB's training inputs.
- Owns a clear sequencer that sweeps every BTB entry on a flush request (context switch / fence), with a clear-index port.
- Sits between commit logic and btb.

Parameters:
- ADDR, 32, address width.
- BTB_D, 32, BTB entries; power of two.
- SIMBRCOM, 1, simultaneous commit updates per cycle; 1..4.
- QDEPTH, 4, update FIFO depth; power of two, >= SIMBRCOM.
- DCNT, 8, width of the drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- upd_valid  in  SIMBRCOM  per-slot commit update valid.
- upd_taken  in  SIMBRCOM  per-slot branch resolved taken.
- upd_addr  in  SIMBRCOM*ADDR  per-slot branch PC; slot n at [n*ADDR +: ADDR].
- upd_tar  in  SIMBRCOM*ADDR  per-slot target address.
- upd_ready  out  1  FIFO can absorb SIMBRCOM entries this cycle.
- flush_req  in  1  single-cycle pulse requesting a full BTB clear.
- flush_busy  out  1  clear sweep in progress.
- pc_chg_com_  out  1  active-low BTB train enable.
- chg_taken_  out  1  active-low taken flag to BTB.
- com_addr  out  ADDR  branch PC to BTB.
- com_tar_addr  out  ADDR  target to BTB.
- btb_clr  out  1  invalidate entry btb_clr_idx this cycle.
- btb_clr_idx  out  log2(BTB_D)  entry to invalidate.
- drop_cnt  out  DCNT  saturating count of discarded updates.

Behaviour:
- Reset values:
  - FSM IDLE; FIFO empty.
  - pc_chg_com_=1, chg_taken_=1, com_addr=0, com_tar_addr=0.
  - btb_clr=0, btb_clr_idx=0, flush_busy=0, drop_cnt=0.
  - upd_ready=0 while reset is high, then 1.
- All outputs are registered.
- FSM states IDLE and CLEAR.
- upd_ready = (state==IDLE) && (free slots >= SIMBRCOM). It is combinational from registered state.
- Enqueue, IDLE only: valid slots are written in ascending slot order into consecutive FIFO entries. Invalid slots are skipped, with no holes.
  - Slots presented while upd_ready=0 are discarded.
  - drop_cnt += popcount(upd_valid) on a discard, saturating at all-ones.
- Dequeue, IDLE, FIFO non-empty: the head entry is popped.
  - Next cycle: pc_chg_com_=0, chg_taken_=!taken, com_addr/com_tar_addr = entry.
  - Otherwise pc_chg_com_=1 and the data outputs hold their last value.
  - Throughput is 1 update/cycle. Minimum latency is 2 cycles: enqueue at edge N, BTB pulse visible after edge N+1.
- Simultaneous enqueue and dequeue in the same cycle are allowed. Occupancy change = enq_count - 1. A full FIFO with a dequeue still reports upd_ready from pre-dequeue occupancy (conservative).
- IDLE -> CLEAR on flush_req=1:
  - FIFO is emptied.
  - Same-cycle upd_valid slots are discarded and counted.
  - btb_clr_idx is loaded with 0.
- CLEAR:
  - Each cycle: btb_clr=1, flush_busy=1, pc_chg_com_=1.
  - btb_clr_idx increments by 1 each cycle.
  - After the cycle presenting idx BTB_D-1, go to IDLE, with btb_clr=0 and flush_busy=0. This is exactly BTB_D clear cycles.
  - flush_req during CLEAR is ignored.
  - upd_valid during CLEAR is discarded and counted.
- btb_clr and pc_chg_com_=0 are never asserted in the same cycle.
- Reset asserted mid-CLEAR or mid-drain: immediate return to reset values. No partial sweep resumes.
- Pointer wrap: read/write pointers are log2(QDEPTH)+1 bits. Full/empty are resolved by the MSB compare.

Decomposition:
- Shared package btb_pkg holds:
  - btb_upd_t struct {taken, addr, tar};
  - state enum {BTB_SCHED_IDLE, BTB_SCHED_CLEAR};
  - BtbIdxW = $clog2(BTB_D).
- Sub-module btb_upd_fifo: parameterised multi-push (SIMBRCOM), single-pop FIFO with free-count output.
- The scheduler FSM, clear counter and drop counter stay in btb_upd_sched.

Test Plan:
- Single update:
  - Stimulus: after reset deassert, upd_valid=1, taken=1, addr=32'hdeadbe74, tar=32'hcafecafe for one cycle.
  - Required: exactly one cycle with pc_chg_com_=0, chg_taken_=0, com_addr=deadbe74, com_tar_addr=cafecafe, 2 cycles later.
- Backpressure:
  - Stimulus: 6 consecutive updates with QDEPTH=4, SIMBRCOM=1, addrs 0x100..0x114 step 4.
  - Required: upd_ready never drops (drain keeps pace); all 6 emerge in order; drop_cnt=0.
- Overflow, with dequeue suppressed by holding the FSM in CLEAR:
  - Stimulus: flush_req, then 3 updates during CLEAR.
  - Required: drop_cnt=3; no pc_chg_com_ pulse; btb_clr high for exactly 32 cycles with idx 0..31; flush_busy falls together with btb_clr.
- Simultaneous events:
  - Stimulus: flush_req and upd_valid in the same cycle, FIFO holding 2 entries.
  - Required: both queued entries are lost; drop_cnt=1; the next BTB write only follows a new update after CLEAR ends.
- Reset mid-clear:
  - Stimulus: assert reset at btb_clr_idx=10.
  - Required: btb_clr=0, btb_clr_idx=0, flush_busy=0 asynchronously.
  - Required: after deassert, an update issues normally.
- SIMBRCOM=2 ordering:
  - Stimulus: slots {1:valid addr 0x200, 0:valid addr 0x300}, then next cycle {slot1 only, 0x400}.
  - Required: BTB writes appear in order 0x300, 0x200, 0x400.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types for the BTB training-port scheduler.
// Default geometry and helpers used by the scheduler and its FIFO.
package btb_pkg;

  localparam int BtbAddrW = 32;
  localparam int BtbDepth = 32;
  localparam int BtbIdxW  = $clog2(BtbDepth);

  typedef struct packed {
    logic                taken;
    logic [BtbAddrW-1:0] addr;
    logic [BtbAddrW-1:0] tar;
  } btb_upd_t;

  typedef enum logic {
    BTB_SCHED_IDLE,
    BTB_SCHED_CLEAR
  } sched_state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Multi-push, single-pop FIFO for BTB training updates.
// Valid push slots are packed in ascending order with no holes.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int W     = 65,
  parameter int NPUSH = 1,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [NPUSH-1:0] push_vld,
  input  logic [NPUSH*W-1:0] push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             empty,
  output logic [AW:0]      free
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [AW:0]   wp;
  logic [AW-1:0] slot_idx [NPUSH];

  assign empty = (wptr_q == rptr_q);
  assign free  = (AW+1)'(DEPTH) - (wptr_q - rptr_q);
  assign head  = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wp = wptr_q;
    for (int i = 0; i < NPUSH; i++) begin
      slot_idx[i] = wp[AW-1:0];
      if (push && push_vld[i]) wp = wp + (AW+1)'(1);
    end
    wptr_d = wp;
    rptr_d = rptr_q + (AW+1)'(pop);
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPUSH; i++) begin
      if (push && push_vld[i]) mem_q[slot_idx[i]] <= push_data[i*W +: W];
    end
  end

endmodule

// File: rtl/btb_upd_sched.sv
// Arbitrates the BTB training port between commit updates
// and a full-table clear sweep; counts discarded updates.
module btb_upd_sched
  import btb_pkg::*;
#(
  parameter int ADDR     = 32,
  parameter int BTB_D    = 32,
  parameter int SIMBRCOM = 1,
  parameter int QDEPTH   = 4,
  parameter int DCNT     = 8,
  localparam int IdxW    = $clog2(BTB_D)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIMBRCOM-1:0]      upd_valid,
  input  logic [SIMBRCOM-1:0]      upd_taken,
  input  logic [SIMBRCOM*ADDR-1:0] upd_addr,
  input  logic [SIMBRCOM*ADDR-1:0] upd_tar,
  output logic                     upd_ready,
  input  logic                     flush_req,
  output logic                     flush_busy,
  output logic                     pc_chg_com_,
  output logic                     chg_taken_,
  output logic [ADDR-1:0]          com_addr,
  output logic [ADDR-1:0]          com_tar_addr,
  output logic                     btb_clr,
  output logic [IdxW-1:0]          btb_clr_idx,
  output logic [DCNT-1:0]          drop_cnt
);

  localparam int QAW = $clog2(QDEPTH);
  localparam int UW  = 1 + 2*ADDR;

  sched_state_e state_q, state_d;

  logic [QAW:0]           free;
  logic                   empty;
  logic [UW-1:0]          head;
  logic [SIMBRCOM*UW-1:0] push_data;
  logic                   h_taken;
  logic [ADDR-1:0]        h_addr, h_tar;
  logic                   idle, enq, deq, clr_go;
  logic [3:0]             vld4;
  logic [2:0]             nvld;
  logic [DCNT:0]          drop_sum;

  logic            pc_chg_q, pc_chg_d;
  logic            tkn_n_q, tkn_n_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR-1:0] tar_q, tar_d;
  logic            clr_q, clr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            busy_q, busy_d;
  logic [DCNT-1:0] drop_q, drop_d;

  assign idle      = (state_q == BTB_SCHED_IDLE);
  assign upd_ready = !reset && idle && (free >= (QAW+1)'(SIMBRCOM));
  assign enq       = upd_ready && !flush_req;
  assign deq       = idle && !empty && !flush_req;
  assign clr_go    = idle && flush_req;

  assign {h_taken, h_addr, h_tar} = head;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < SIMBRCOM; i++) begin
      push_data[i*UW +: UW] = {upd_taken[i],
                               upd_addr[i*ADDR +: ADDR],
                               upd_tar[i*ADDR +: ADDR]};
    end
  end

  btb_upd_fifo #(
    .W     (UW),
    .NPUSH (SIMBRCOM),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .clr       (clr_go),
    .push      (enq),
    .push_vld  (upd_valid),
    .push_data (push_data),
    .pop       (deq),
    .head      (head),
    .empty     (empty),
    .free      (free)
  );

  always_comb begin
    vld4 = '0;
    vld4[SIMBRCOM-1:0] = upd_valid;
    nvld = popcnt4(vld4);
    drop_sum = {1'b0, drop_q} + (DCNT+1)'(nvld);

    state_d  = state_q;
    pc_chg_d = 1'b1;
    tkn_n_d  = tkn_n_q;
    addr_d   = addr_q;
    tar_d    = tar_q;
    clr_d    = clr_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    drop_d   = drop_q;

    // Anything presented and not absorbed is counted, saturating.
    if (!enq && nvld != 3'd0) begin
      drop_d = drop_sum[DCNT] ? '1 : drop_sum[DCNT-1:0];
    end

    unique case (state_q)
      BTB_SCHED_IDLE: begin
        if (flush_req) begin
          state_d = BTB_SCHED_CLEAR;
          clr_d   = 1'b1;
          busy_d  = 1'b1;
          idx_d   = '0;
        end else if (deq) begin
          pc_chg_d = 1'b0;
          tkn_n_d  = !h_taken;
          addr_d   = h_addr;
          tar_d    = h_tar;
        end
      end
      BTB_SCHED_CLEAR: begin
        idx_d = idx_q + IdxW'(1);
        if (idx_q == IdxW'(BTB_D-1)) begin
          state_d = BTB_SCHED_IDLE;
          clr_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      default: state_d = BTB_SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= BTB_SCHED_IDLE;
      pc_chg_q <= 1'b1;
      tkn_n_q  <= 1'b1;
      addr_q   <= '0;
      tar_q    <= '0;
      clr_q    <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_chg_q <= pc_chg_d;
      tkn_n_q  <= tkn_n_d;
      addr_q   <= addr_d;
      tar_q    <= tar_d;
      clr_q    <= clr_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      drop_q   <= drop_d;
    end
  end

  assign pc_chg_com_  = pc_chg_q;
  assign chg_taken_   = tkn_n_q;
  assign com_addr     = addr_q;
  assign com_tar_addr = tar_q;
  assign btb_clr      = clr_q;
  assign btb_clr_idx  = idx_q;
  assign flush_busy   = busy_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_btb_upd_sched.sv
// Bench for btb_upd_sched: one-slot and two-slot instances checked
// against a queue-based model, plus table vectors and corner sequences.
module tb_btb_upd_sched;

  typedef struct packed {
    logic        tk;
    logic [31:0] a;
    logic [31:0] t;
  } ent_t;

  typedef struct packed {
    logic        vld;
    logic        tk;
    logic [31:0] a;
    logic [31:0] t;
    logic        e_pcn;
    logic        e_tkn;
    logic [31:0] e_a;
    logic [31:0] e_t;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       fl;
  logic [1:0][1:0]  vld, tkn;
  logic [1:0][63:0] adr, tar;
  wire  [1:0]       rdy, pcn, tkn_n, busy, clr;
  wire  [1:0][31:0] ca, ct;
  wire  [1:0][4:0]  idx;
  wire  [1:0][7:0]  drp;

  int ncmp = 0;
  int nerr = 0;

  ent_t        mq [2][$];
  int          m_drop [2];
  bit          m_clr  [2];
  int          m_idx  [2];
  bit          m_pcn  [2];
  bit          m_tkn  [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_t    [2];

  vec_t tv [11];

  btb_upd_sched #(.ADDR(32), .BTB_D(32), .SIMBRCOM(1), .QDEPTH(4), .DCNT(8)) u0 (
    .clk(clk), .reset(rst),
    .upd_valid(vld[0][0]), .upd_taken(tkn[0][0]),
    .upd_addr(adr[0][31:0]), .upd_tar(tar[0][31:0]),
    .upd_ready(rdy[0]), .flush_req(fl[0]), .flush_busy(busy[0]),
    .pc_chg_com_(pcn[0]), .chg_taken_(tkn_n[0]),
    .com_addr(ca[0]), .com_tar_addr(ct[0]),
    .btb_clr(clr[0]), .btb_clr_idx(idx[0]), .drop_cnt(drp[0])
  );

  btb_upd_sched #(.ADDR(32), .BTB_D(32), .SIMBRCOM(2), .QDEPTH(4), .DCNT(8)) u1 (
    .clk(clk), .reset(rst),
    .upd_valid(vld[1]), .upd_taken(tkn[1]),
    .upd_addr(adr[1]), .upd_tar(tar[1]),
    .upd_ready(rdy[1]), .flush_req(fl[1]), .flush_busy(busy[1]),
    .pc_chg_com_(pcn[1]), .chg_taken_(tkn_n[1]),
    .com_addr(ca[1]), .com_tar_addr(ct[1]),
    .btb_clr(clr[1]), .btb_clr_idx(idx[1]), .drop_cnt(drp[1])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic v, logic tk, logic [31:0] a, logic [31:0] t,
                              logic pn, logic tn, logic [31:0] ea, logic [31:0] et);
    vec_t r;
    r.vld = v; r.tk = tk; r.a = a; r.t = t;
    r.e_pcn = pn; r.e_tkn = tn; r.e_a = ea; r.e_t = et;
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      m_drop[d] = 0; m_clr[d] = 1'b0; m_idx[d] = 0;
      m_pcn[d] = 1'b1; m_tkn[d] = 1'b1; m_a[d] = '0; m_t[d] = '0;
    end
  endtask

  function automatic bit m_rdy(int d, int s);
    return !m_clr[d] && ((4 - mq[d].size()) >= s);
  endfunction

  task automatic add_drop(int d, int n);
    m_drop[d] = (m_drop[d] + n > 255) ? 255 : m_drop[d] + n;
  endtask

  // Next-cycle expectations from the current inputs.
  task automatic model_step(int d, int s);
    int   n;
    bit   r;
    ent_t e;
    n = 0;
    for (int i = 0; i < s; i++) if (vld[d][i]) n++;
    m_pcn[d] = 1'b1;
    if (m_clr[d]) begin
      add_drop(d, n);
      if (m_idx[d] == 31) begin
        m_clr[d] = 1'b0; m_idx[d] = 0;
      end else m_idx[d]++;
    end else if (fl[d]) begin
      add_drop(d, n);
      mq[d].delete();
      m_clr[d] = 1'b1; m_idx[d] = 0;
    end else begin
      r = m_rdy(d, s);
      if (mq[d].size() > 0) begin
        e = mq[d].pop_front();
        m_pcn[d] = 1'b0; m_tkn[d] = !e.tk; m_a[d] = e.a; m_t[d] = e.t;
      end
      if (r) begin
        for (int i = 0; i < s; i++)
          if (vld[d][i]) mq[d].push_back({tkn[d][i], adr[d][i*32 +: 32], tar[d][i*32 +: 32]});
      end else add_drop(d, n);
    end
  endtask

  task automatic check_regs(int d);
    chk($sformatf("pcn%0d", d),  32'(pcn[d]),   32'(m_pcn[d]));
    chk($sformatf("tkn%0d", d),  32'(tkn_n[d]), 32'(m_tkn[d]));
    chk($sformatf("addr%0d", d), ca[d],         m_a[d]);
    chk($sformatf("tar%0d", d),  ct[d],         m_t[d]);
    chk($sformatf("clr%0d", d),  32'(clr[d]),   32'(m_clr[d]));
    chk($sformatf("busy%0d", d), 32'(busy[d]),  32'(m_clr[d]));
    chk($sformatf("idx%0d", d),  32'(idx[d]),   m_idx[d]);
    chk($sformatf("drop%0d", d), 32'(drp[d]),   m_drop[d]);
  endtask

  task automatic check_dut(int d, int s);
    check_regs(d);
    chk($sformatf("rdy%0d", d), 32'(rdy[d]), 32'(m_rdy(d, s)));
  endtask

  task automatic cyc();
    model_step(0, 1);
    model_step(1, 2);
    @(posedge clk); #1;
    check_dut(0, 1);
    check_dut(1, 2);
  endtask

  task automatic idle_in();
    vld = '0; fl = '0; tkn = '0; adr = '0; tar = '0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    check_regs(0); check_regs(1);
    chk("rst_rdy0", 32'(rdy[0]), 0);
    chk("rst_rdy1", 32'(rdy[1]), 0);
    rst = 1'b0;
    #1;
    check_dut(0, 1); check_dut(1, 2);
  endtask

  initial begin
    int nclr, npulse, nlow;
    logic [31:0] got [$];

    tv[0] = mk(1, 1, 32'hdeadbe74, 32'hcafecafe, 1, 1, 0, 0);
    tv[1] = mk(0, 0, 0, 0, 0, 0, 32'hdeadbe74, 32'hcafecafe);
    tv[2] = mk(0, 0, 0, 0, 1, 0, 32'hdeadbe74, 32'hcafecafe);
    for (int k = 0; k < 6; k++) begin
      if (k == 0)
        tv[3+k] = mk(1, 0, 32'h100, 32'h1000, 1, 0, 32'hdeadbe74, 32'hcafecafe);
      else
        tv[3+k] = mk(1, (k % 2 == 1), 32'h100 + 4*k, 32'h1000 + k,
                     0, !((k-1) % 2 == 1), 32'h100 + 4*(k-1), 32'h1000 + k - 1);
    end
    tv[9]  = mk(0, 0, 0, 0, 0, 0, 32'h114, 32'h1005);
    tv[10] = mk(0, 0, 0, 0, 1, 0, 32'h114, 32'h1005);

    // Single update then back-to-back stream on the one-slot instance.
    do_reset();
    nlow = 0;
    for (int i = 0; i < 11; i++) begin
      idle_in();
      vld[0] = {1'b0, tv[i].vld};
      tkn[0] = {1'b0, tv[i].tk};
      adr[0] = {32'h0, tv[i].a};
      tar[0] = {32'h0, tv[i].t};
      if (!rdy[0]) nlow++;
      cyc();
      chk($sformatf("tv%0d_pcn", i), 32'(pcn[0]), 32'(tv[i].e_pcn));
      chk($sformatf("tv%0d_tkn", i), 32'(tkn_n[0]), 32'(tv[i].e_tkn));
      chk($sformatf("tv%0d_addr", i), ca[0], tv[i].e_a);
      chk($sformatf("tv%0d_tar", i), ct[0], tv[i].e_t);
    end
    chk("bp_ready_low", nlow, 0);
    chk("bp_drop", 32'(drp[0]), 0);

    // Updates arriving during a clear sweep are all discarded.
    do_reset();
    fl[0] = 1'b1;
    cyc();
    idle_in();
    nclr = 0; npulse = 0;
    for (int n = 0; n < 40 && clr[0]; n++) begin
      chk("ovf_idx", 32'(idx[0]), nclr);
      nclr++;
      if (!pcn[0]) npulse++;
      idle_in();
      if (n < 3) begin
        vld[0] = 2'b01;
        adr[0] = {32'h0, 32'h300 + 4*n};
      end
      cyc();
    end
    chk("ovf_nclr", nclr, 32);
    chk("ovf_busy", 32'(busy[0]), 0);
    chk("ovf_drop", 32'(drp[0]), 3);
    chk("ovf_pulse", npulse, 0);

    // Flush with two entries queued and one update in the same cycle.
    do_reset();
    vld[1] = 2'b11;
    adr[1] = {32'h604, 32'h600};
    cyc();
    idle_in();
    fl[1]  = 1'b1;
    vld[1] = 2'b01;
    adr[1] = {32'h0, 32'h608};
    cyc();
    idle_in();
    chk("sim_drop", 32'(drp[1]), 1);
    npulse = 0;
    for (int n = 0; n < 40 && clr[1]; n++) begin
      if (!pcn[1]) npulse++;
      cyc();
    end
    chk("sim_clr_end", 32'(clr[1]), 0);
    chk("sim_pulse", npulse, 0);
    vld[1] = 2'b01;
    adr[1] = {32'h0, 32'h500};
    cyc();
    idle_in();
    cyc();
    chk("sim_new_pcn", 32'(pcn[1]), 0);
    chk("sim_new_addr", ca[1], 32'h500);

    // Reset in the middle of a sweep.
    do_reset();
    fl[0] = 1'b1;
    cyc();
    idle_in();
    for (int n = 0; n < 40 && idx[0] != 5'd10; n++) cyc();
    chk("mid_idx10", 32'(idx[0]), 10);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_clr", 32'(clr[0]), 0);
    chk("mid_idx", 32'(idx[0]), 0);
    chk("mid_busy", 32'(busy[0]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    vld[0] = 2'b01;
    tkn[0] = 2'b01;
    adr[0] = {32'h0, 32'h700};
    tar[0] = {32'h0, 32'h7700};
    cyc();
    idle_in();
    cyc();
    chk("mid_after_pcn", 32'(pcn[0]), 0);
    chk("mid_after_addr", ca[0], 32'h700);
    chk("mid_after_tkn", 32'(tkn_n[0]), 0);

    // Two-slot ordering: slot 0 precedes slot 1.
    do_reset();
    vld[1] = 2'b11;
    adr[1] = {32'h200, 32'h300};
    cyc();
    if (!pcn[1]) got.push_back(ca[1]);
    idle_in();
    vld[1] = 2'b10;
    adr[1] = {32'h400, 32'h0};
    cyc();
    if (!pcn[1]) got.push_back(ca[1]);
    idle_in();
    for (int n = 0; n < 6; n++) begin
      cyc();
      if (!pcn[1]) got.push_back(ca[1]);
    end
    chk("ord_cnt", got.size(), 3);
    if (got.size() == 3) begin
      chk("ord_0", got[0], 32'h300);
      chk("ord_1", got[1], 32'h200);
      chk("ord_2", got[2], 32'h400);
    end

    // Drop counter saturation.
    do_reset();
    vld[1] = 2'b11;
    fl[1]  = 1'b1;
    for (int n = 0; n < 170; n++) cyc();
    chk("sat_drop", 32'(drp[1]), 255);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int d = 0; d < 2; d++) begin
        fl[d]  = ($urandom_range(0, 59) == 0);
        vld[d] = 2'($urandom);
        tkn[d] = 2'($urandom);
        adr[d] = {$urandom, $urandom};
        tar[d] = {$urandom, $urandom};
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
